a4l_slave_regbank: RTL and testbench
====================================

A4L_SLAVE_REGBANK -- requirements
Module: a4l_slave_regbank

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h4152_0001, the read-only identification word at offset 0x00.
REQ-002 SHALL have bridge_Clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have bridge_Reset_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have the AXI4-Lite write-address ports:
- axiS0_AWVALID, input, 1.
- axiS0_AWREADY, output, 1.
- axiS0_AWADDR, input, 20, 1MB window.
- axiS0_AWPROT, input, 3, ignored.
REQ-005 SHALL have the write-data ports: axiS0_WVALID in 1; axiS0_WREADY out 1; axiS0_WDATA in 32; axiS0_WSTRB in 4.
REQ-006 SHALL have the write-response ports: axiS0_BVALID out 1; axiS0_BREADY in 1; axiS0_BRESP out 2.
REQ-007 SHALL have the read-address ports: axiS0_ARVALID in 1; axiS0_ARREADY out 1; axiS0_ARADDR in 20; axiS0_ARPROT in 3, ignored.
REQ-008 SHALL have the read-data ports: axiS0_RVALID out 1; axiS0_RREADY in 1; axiS0_RDATA out 32; axiS0_RRESP out 2.
REQ-009 SHALL have ctrl_out, output, 32, the registered contents of register 2.

Function
REQ-010 SHALL provide 16 word registers, selected by ADDR[5:2] (offsets 0x00-0x3C):
- reg0 = ID_VALUE, read-only.
- reg1 = free-running 32b cycle counter, read-only, wraps from 0xFFFF_FFFF to 0.
- reg2-reg15 = read/write.
REQ-011 SHALL treat as an error any access with ADDR[19:6] != 0 or ADDR[1:0] != 0, and any write to reg0 or reg1: the response is SLVERR (2'b10), no state changes, and read data is 0. All other accesses respond OKAY (2'b00).
REQ-012 SHALL capture AW and W independently, in either order or in the same cycle. Once a channel's beat is captured, its READY drops until the write response completes.
REQ-013 SHALL commit the write in the cycle after both AW and W are held (or after both handshake simultaneously): byte lane i updates only when WSTRB[i]=1. BVALID rises in that same commit cycle.
REQ-014 SHALL hold BVALID and BRESP stable until BREADY=1. AWREADY and WREADY return to 1 in the cycle after the B handshake.
REQ-015 SHALL implement the write FSM with states W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP:
- W_IDLE -> W_HAVE_A on AW only.
- W_IDLE -> W_HAVE_D on W only.
- W_IDLE -> W_RESP on both.
- W_HAVE_A -> W_RESP on W; W_HAVE_D -> W_RESP on AW.
- W_RESP -> W_IDLE on BREADY.
REQ-016 SHALL implement the read FSM with states R_IDLE, R_RESP:
- ARREADY=1 only in R_IDLE.
- An AR handshake in cycle N gives RVALID=1 in N+1, with RDATA/RRESP registered at acceptance.
- RDATA/RRESP are held until RREADY=1, then the FSM returns to R_IDLE.
REQ-017 SHALL return the pre-write value when a read accepted in cycle N targets a register committed in cycle N.
REQ-018 SHALL return the counter value sampled in the AR-acceptance cycle for a read of reg1.
REQ-019 SHALL run the read and write FSMs fully concurrently with no mutual stalls; the maximum throughput is one write per 2 cycles and one read per 2 cycles.
REQ-020 SHALL keep every output registered; there are no combinational paths from inputs to outputs.

Reset
REQ-021 SHALL, while bridge_Reset_n=0, drive AWREADY=WREADY=ARREADY=BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, reg1=0, reg2-reg15=0, ctrl_out=0, and hold both FSMs in their IDLE states.
REQ-022 SHALL assert the READY outputs at the first rising edge sampling bridge_Reset_n=1.
REQ-023 SHALL abandon any in-flight transaction when reset is asserted mid-operation; no response is issued for it.

Structure
REQ-024 SHALL place in a shared package: the register offset constants, the OKAY/SLVERR encodings, the ID_VALUE default, and the FSM state enumerations.
REQ-025 SHALL use one sub-module, a4l_regbank_core: the 14x32 byte-strobed register array plus the counter, with a one-port write and a one-port combinational read.

Verification
REQ-026 Write 0xA5A5_1234, WSTRB=4'hF, to 0x08 with AW and W in the same cycle -> BVALID the next cycle with BRESP=00; ctrl_out=0xA5A5_1234.
REQ-027 W to 0x0C presented 3 cycles before AW, data 0xFFFF_FFFF, WSTRB=4'b0101 -> a later read of 0x0C returns 0x00FF_00FF with RRESP=00.
REQ-028 Read 0x00 -> RDATA=0x4152_0001 one cycle after AR. Write 0x00 -> BRESP=10 and a re-read still returns 0x4152_0001.
REQ-029 Read 0x40 and read 0x0000_2 -> RRESP=10, RDATA=0. A write to 0x80 -> BRESP=10 and no register changes.
REQ-030 BREADY held low for 10 cycles -> BVALID and BRESP stable throughout and AWREADY/WREADY stay 0; a concurrent read of 0x04 completes and returns a nonzero count.
REQ-031 Reset asserted while in W_HAVE_A -> the cycle after release shows BVALID=0, all READYs=1, and reading 0x08 returns 0.

Source files
------------

// File: rtl/a4l_slave_regbank_pkg.sv
// Shared definitions for the AXI4-Lite register bank: geometry, register
// offsets, response encodings, FSM state types and the address decode rule.
package a4l_slave_regbank_pkg;

  localparam int unsigned ADDR_W   = 20;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned NUM_RW   = NUM_REGS - 2;

  // Byte offsets of the fixed registers inside the 64-byte window
  localparam logic [5:0] OFF_ID   = 6'h00;
  localparam logic [5:0] OFF_CNT  = 6'h04;
  localparam logic [5:0] OFF_CTRL = 6'h08;

  // Word indices derived from the offsets (ADDR[5:2])
  localparam logic [3:0] IDX_ID   = OFF_ID[5:2];
  localparam logic [3:0] IDX_CNT  = OFF_CNT[5:2];
  localparam logic [3:0] IDX_CTRL = OFF_CTRL[5:2];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [DATA_W-1:0] ID_VALUE_DEF = 32'h4152_0001;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_A,
    W_HAVE_D,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

  // An access is bad if it leaves the 64-byte window, is not word aligned,
  // or is a write aimed at one of the read-only registers (ID, counter).
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr,
                                    input logic              is_write);
    logic out_of_window;
    logic misaligned;
    logic ro_target;
    out_of_window = |addr[ADDR_W-1:6];
    misaligned    = |addr[1:0];
    ro_target     = is_write && (addr[5:2] < IDX_CTRL);
    return out_of_window || misaligned || ro_target;
  endfunction

endpackage

// File: rtl/a4l_regbank_core.sv
// Register storage: 14 byte-strobed read/write words, a free-running cycle
// counter and the constant ID word, with one write port and one
// combinational read port.
module a4l_regbank_core
  import a4l_slave_regbank_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE = ID_VALUE_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [3:0]        widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [STRB_W-1:0] wstrb_i,
  input  logic [3:0]        ridx_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] rw_q [NUM_RW];
  logic [DATA_W-1:0] cnt_q;
  logic [3:0]        wrel;
  logic [3:0]        rrel;

  // Storage index 0 holds register 2, so rebase both port indices
  assign wrel = widx_i - IDX_CTRL;
  assign rrel = ridx_i - IDX_CTRL;

  // Read/write words: cleared by reset, byte lanes updated under strobe
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_RW; i++) begin
        rw_q[i] <= '0;
      end
    end else if (we_i && (widx_i >= IDX_CTRL)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) begin
          rw_q[wrel][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Free-running cycle counter, wraps naturally at 2^32
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Combinational read mux over ID, counter and the read/write words
  always_comb begin
    rdata_o = '0;
    unique case (ridx_i)
      IDX_ID:  rdata_o = ID_VALUE;
      IDX_CNT: rdata_o = cnt_q;
      default: rdata_o = rw_q[rrel];
    endcase
  end

  assign ctrl_o = rw_q[0];

endmodule

// File: rtl/a4l_slave_regbank.sv
// AXI4-Lite slave front end for the 16-word register bank. Independent
// write (AW/W/B) and read (AR/R) state machines; every output is a flop.
module a4l_slave_regbank
  import a4l_slave_regbank_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE = ID_VALUE_DEF
) (
  input  logic              bridge_Clk,
  input  logic              bridge_Reset_n,
  // write address
  input  logic              axiS0_AWVALID,
  output logic              axiS0_AWREADY,
  input  logic [ADDR_W-1:0] axiS0_AWADDR,
  input  logic [2:0]        axiS0_AWPROT,
  // write data
  input  logic              axiS0_WVALID,
  output logic              axiS0_WREADY,
  input  logic [DATA_W-1:0] axiS0_WDATA,
  input  logic [STRB_W-1:0] axiS0_WSTRB,
  // write response
  output logic              axiS0_BVALID,
  input  logic              axiS0_BREADY,
  output logic [1:0]        axiS0_BRESP,
  // read address
  input  logic              axiS0_ARVALID,
  output logic              axiS0_ARREADY,
  input  logic [ADDR_W-1:0] axiS0_ARADDR,
  input  logic [2:0]        axiS0_ARPROT,
  // read data
  output logic              axiS0_RVALID,
  input  logic              axiS0_RREADY,
  output logic [DATA_W-1:0] axiS0_RDATA,
  output logic [1:0]        axiS0_RRESP,
  // register 2 contents
  output logic [DATA_W-1:0] ctrl_out
);

  wr_state_e         wr_state_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  rd_state_e         rd_state_q;
  logic              arready_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_fire;
  logic              wr_err;
  logic              rd_err;
  logic [ADDR_W-1:0] wr_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;
  logic [STRB_W-1:0] wr_strb_sel;
  logic              core_we;
  logic [DATA_W-1:0] core_rdata;

  // Protection bits carry no meaning for this bank
  logic unused_prot;
  assign unused_prot = ^{axiS0_AWPROT, axiS0_ARPROT};

  assign aw_hs = axiS0_AWVALID && awready_q;
  assign w_hs  = axiS0_WVALID  && wready_q;
  assign ar_hs = axiS0_ARVALID && arready_q;

  // Write commit: fires on the edge that completes the AW/W pair, taking
  // whichever half arrives now straight from the bus and the other from
  // the holding registers
  always_comb begin
    wr_addr_sel = aw_hs ? axiS0_AWADDR : awaddr_q;
    wr_data_sel = w_hs  ? axiS0_WDATA  : wdata_q;
    wr_strb_sel = w_hs  ? axiS0_WSTRB  : wstrb_q;
    wr_fire     = 1'b0;
    unique case (wr_state_q)
      W_IDLE:   wr_fire = aw_hs && w_hs;
      W_HAVE_A: wr_fire = w_hs;
      W_HAVE_D: wr_fire = aw_hs;
      default:  wr_fire = 1'b0;
    endcase
    wr_err  = addr_err(wr_addr_sel, 1'b1);
    core_we = wr_fire && !wr_err;
  end

  assign rd_err = addr_err(axiS0_ARADDR, 1'b0);

  // Holding registers for a beat that arrives before its partner
  always_ff @(posedge bridge_Clk) begin
    if (aw_hs) begin
      awaddr_q <= axiS0_AWADDR;
    end
    if (w_hs) begin
      wdata_q <= axiS0_WDATA;
      wstrb_q <= axiS0_WSTRB;
    end
  end

  // Write FSM: captures AW and W in any order, then holds B until BREADY
  always_ff @(posedge bridge_Clk) begin
    if (!bridge_Reset_n) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      unique case (wr_state_q)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state_q <= W_RESP;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_err ? RESP_SLVERR : RESP_OKAY;
          end else if (aw_hs) begin
            wr_state_q <= W_HAVE_A;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
          end else if (w_hs) begin
            wr_state_q <= W_HAVE_D;
            awready_q  <= 1'b1;
            wready_q   <= 1'b0;
          end else begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        W_HAVE_A: begin
          if (w_hs) begin
            wr_state_q <= W_RESP;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_HAVE_D: begin
          if (aw_hs) begin
            wr_state_q <= W_RESP;
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        W_RESP: begin
          if (axiS0_BREADY) begin
            wr_state_q <= W_IDLE;
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        default: begin
          wr_state_q <= W_IDLE;
          awready_q  <= 1'b0;
          wready_q   <= 1'b0;
          bvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: samples data and response at AR acceptance, holds until RREADY
  always_ff @(posedge bridge_Clk) begin
    if (!bridge_Reset_n) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state_q <= R_RESP;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rresp_q    <= rd_err ? RESP_SLVERR : RESP_OKAY;
            rdata_q    <= rd_err ? '0 : core_rdata;
          end else begin
            arready_q  <= 1'b1;
          end
        end
        R_RESP: begin
          if (axiS0_RREADY) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
          end
        end
        default: begin
          rd_state_q <= R_IDLE;
          arready_q  <= 1'b0;
          rvalid_q   <= 1'b0;
        end
      endcase
    end
  end

  a4l_regbank_core #(
    .ID_VALUE (ID_VALUE)
  ) u_core (
    .clk_i   (bridge_Clk),
    .rst_n_i (bridge_Reset_n),
    .we_i    (core_we),
    .widx_i  (wr_addr_sel[5:2]),
    .wdata_i (wr_data_sel),
    .wstrb_i (wr_strb_sel),
    .ridx_i  (axiS0_ARADDR[5:2]),
    .rdata_o (core_rdata),
    .ctrl_o  (ctrl_out)
  );

  assign axiS0_AWREADY = awready_q;
  assign axiS0_WREADY  = wready_q;
  assign axiS0_BVALID  = bvalid_q;
  assign axiS0_BRESP   = bresp_q;
  assign axiS0_ARREADY = arready_q;
  assign axiS0_RVALID  = rvalid_q;
  assign axiS0_RRESP   = rresp_q;
  assign axiS0_RDATA   = rdata_q;

endmodule

// File: tb/tb_a4l_slave_regbank.sv
// Self-checking bench for a4l_slave_regbank: directed scenarios plus a
// randomized mix of reads and writes checked against a register-map model.
module tb_a4l_slave_regbank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        AWVALID = 1'b0, AWREADY;
  logic [19:0] AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        WVALID = 1'b0, WREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        BVALID, BREADY = 1'b0;
  logic [1:0]  BRESP;
  logic        ARVALID = 1'b0, ARREADY;
  logic [19:0] ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        RVALID, RREADY = 1'b0;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic [31:0] ctrl_out;

  localparam logic [31:0] ID_EXP = 32'h4152_0001;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: register contents and elapsed cycles since reset
  logic [31:0] mdl [16];
  logic [31:0] tb_cyc = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 1;
  end

  a4l_slave_regbank dut (
    .bridge_Clk     (clk),
    .bridge_Reset_n (rst_n),
    .axiS0_AWVALID  (AWVALID),
    .axiS0_AWREADY  (AWREADY),
    .axiS0_AWADDR   (AWADDR),
    .axiS0_AWPROT   (AWPROT),
    .axiS0_WVALID   (WVALID),
    .axiS0_WREADY   (WREADY),
    .axiS0_WDATA    (WDATA),
    .axiS0_WSTRB    (WSTRB),
    .axiS0_BVALID   (BVALID),
    .axiS0_BREADY   (BREADY),
    .axiS0_BRESP    (BRESP),
    .axiS0_ARVALID  (ARVALID),
    .axiS0_ARREADY  (ARREADY),
    .axiS0_ARADDR   (ARADDR),
    .axiS0_ARPROT   (ARPROT),
    .axiS0_RVALID   (RVALID),
    .axiS0_RREADY   (RREADY),
    .axiS0_RDATA    (RDATA),
    .axiS0_RRESP    (RRESP),
    .ctrl_out       (ctrl_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit m_err(input logic [19:0] a, input bit wr);
    return (a[19:6] != 0) || (a[1:0] != 0) || (wr && (a[5:2] < 2));
  endfunction

  function automatic logic [31:0] m_read(input logic [19:0] a, input logic [31:0] cyc);
    if (m_err(a, 1'b0)) return 32'h0;
    if (a[5:2] == 0) return ID_EXP;
    if (a[5:2] == 1) return cyc;
    return mdl[a[5:2]];
  endfunction

  task automatic m_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!m_err(a, 1'b1))
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl[a[5:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic m_clear();
    for (int i = 0; i < 16; i++) mdl[i] = '0;
  endtask

  // Called at a negedge; returns at a negedge after the B handshake
  task automatic axi_write(input logic [19:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly, output logic [1:0] resp);
    int t = 0;
    bit aw_done = 0, w_done = 0, aw_now, w_now;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && t < 100) begin
      AWVALID = !aw_done && (t >= aw_dly);
      WVALID  = !w_done  && (t >= w_dly);
      aw_now = AWVALID && AWREADY;
      w_now  = WVALID && WREADY;
      @(posedge clk); @(negedge clk);
      aw_done = aw_done | aw_now;
      w_done  = w_done | w_now;
      t++;
    end
    AWVALID = 0; WVALID = 0;
    check_eq("wr_handshake_done", 32'(aw_done && w_done), 32'd1);
    check_eq("bvalid_at_commit", 32'(BVALID), 32'd1);
    resp = BRESP;
    for (int i = 0; i < b_dly; i++) begin
      @(posedge clk); @(negedge clk);
      check_eq("bvalid_hold", 32'(BVALID), 32'd1);
      check_eq("bresp_hold", 32'(BRESP), 32'(resp));
      check_eq("awready_low_in_resp", 32'(AWREADY), 32'd0);
      check_eq("wready_low_in_resp", 32'(WREADY), 32'd0);
    end
    BREADY = 1;
    @(posedge clk); @(negedge clk);
    BREADY = 0;
    check_eq("bvalid_drop", 32'(BVALID), 32'd0);
    check_eq("awready_back", 32'(AWREADY), 32'd1);
    check_eq("wready_back", 32'(WREADY), 32'd1);
  endtask

  // Called at a negedge; returns at a negedge after the R handshake
  task automatic axi_read(input logic [19:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp,
                          output logic [31:0] cyc);
    int t = 0;
    ARADDR = addr; ARVALID = 1;
    while (!ARREADY && t < 100) begin
      @(posedge clk); @(negedge clk);
      t++;
    end
    check_eq("ar_accept_in_time", 32'(t < 100), 32'd1);
    cyc = tb_cyc;
    @(posedge clk); @(negedge clk);
    ARVALID = 0;
    check_eq("rvalid_next_cycle", 32'(RVALID), 32'd1);
    data = RDATA; resp = RRESP;
    for (int i = 0; i < r_dly; i++) begin
      @(posedge clk); @(negedge clk);
      check_eq("rvalid_hold", 32'(RVALID), 32'd1);
      check_eq("rdata_hold", RDATA, data);
    end
    RREADY = 1;
    @(posedge clk); @(negedge clk);
    RREADY = 0;
    check_eq("rvalid_drop", 32'(RVALID), 32'd0);
    check_eq("arready_back", 32'(ARREADY), 32'd1);
  endtask

  task automatic rd_check(input string tag, input logic [19:0] addr, input int r_dly);
    logic [31:0] d, c;
    logic [1:0]  r;
    axi_read(addr, r_dly, d, r, c);
    check_eq({tag, "_data"}, d, m_read(addr, c));
    check_eq({tag, "_resp"}, 32'(r), m_err(addr, 1'b0) ? 32'd2 : 32'd0);
  endtask

  task automatic wr_check(input string tag, input logic [19:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] r;
    axi_write(addr, data, strb, aw_dly, w_dly, b_dly, r);
    m_write(addr, data, strb);
    check_eq({tag, "_bresp"}, 32'(r), m_err(addr, 1'b1) ? 32'd2 : 32'd0);
    check_eq({tag, "_ctrl_out"}, ctrl_out, mdl[2]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, c, old;
    logic [1:0]  r;
    m_clear();

    // reset values
    repeat (3) @(negedge clk);
    check_eq("rst_awready", 32'(AWREADY), 0);
    check_eq("rst_wready", 32'(WREADY), 0);
    check_eq("rst_arready", 32'(ARREADY), 0);
    check_eq("rst_bvalid", 32'(BVALID), 0);
    check_eq("rst_rvalid", 32'(RVALID), 0);
    check_eq("rst_resps", 32'({BRESP, RRESP}), 0);
    check_eq("rst_rdata", RDATA, 0);
    check_eq("rst_ctrl_out", ctrl_out, 0);
    rst_n = 1;
    @(posedge clk); @(negedge clk);
    check_eq("ready_after_release", 32'({AWREADY, WREADY, ARREADY}), 32'b111);

    // same-cycle AW/W to ctrl register
    wr_check("wr08_same", 20'h08, 32'hA5A5_1234, 4'hF, 0, 0, 0);
    check_eq("ctrl_out_A5A5", ctrl_out, 32'hA5A5_1234);

    // W three cycles ahead of AW, partial strobes
    wr_check("wr0C_wfirst", 20'h0C, 32'hFFFF_FFFF, 4'b0101, 3, 0, 0);
    axi_read(20'h0C, 0, d, r, c);
    check_eq("rd0C_strobe", d, 32'h00FF_00FF);
    check_eq("rd0C_resp", 32'(r), 0);

    // ID register and write protection
    rd_check("rd_id", 20'h00, 0);
    wr_check("wr_id", 20'h00, 32'hDEAD_BEEF, 4'hF, 0, 1, 0);
    rd_check("rd_id_again", 20'h00, 1);
    wr_check("wr_cnt", 20'h04, 32'h1234_5678, 4'hF, 1, 0, 0);

    // decode errors
    rd_check("rd_40", 20'h40, 0);
    rd_check("rd_02", 20'h02, 0);
    wr_check("wr_80", 20'h80, 32'h5555_AAAA, 4'hF, 0, 0, 0);
    wr_check("wr_0A", 20'h0A, 32'h5555_AAAA, 4'hF, 0, 0, 0);
    for (int i = 2; i < 16; i++) rd_check("scan_after_err", 20'(i * 4), 0);

    // long BREADY stall with a concurrent counter read
    fork
      wr_check("wr14_stall", 20'h14, 32'hCAFE_0014, 4'hF, 0, 0, 10);
      begin
        repeat (3) @(negedge clk);
        axi_read(20'h04, 2, d, r, c);
        check_eq("cnt_during_stall", d, c);
        check_eq("cnt_nonzero", 32'(d != 0), 1);
      end
    join

    // read accepted on the commit edge sees the old contents
    wr_check("wr10_first", 20'h10, 32'h1111_2222, 4'hF, 0, 0, 0);
    old = mdl[4];
    fork
      wr_check("wr10_second", 20'h10, 32'h3333_4444, 4'hF, 0, 0, 0);
      begin
        axi_read(20'h10, 0, d, r, c);
        check_eq("rd_same_edge_old", d, old);
      end
    join
    rd_check("rd10_new", 20'h10, 0);

    // randomized mix
    for (int n = 0; n < 120; n++) begin
      logic [19:0] a;
      if ($urandom_range(0, 4) == 0) a = 20'($urandom_range(0, 20'hFFFFF));
      else                           a = 20'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 1) == 0)
        wr_check("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        rd_check("rnd_rd", a, $urandom_range(0, 2));
    end

    // reset while holding an address beat
    AWADDR = 20'h08; AWVALID = 1;
    check_eq("mid_awready", 32'(AWREADY), 1);
    @(posedge clk); @(negedge clk);
    AWVALID = 0;
    check_eq("have_a_awready_low", 32'(AWREADY), 0);
    check_eq("have_a_wready_high", 32'(WREADY), 1);
    rst_n = 0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check_eq("mid_rst_readies", 32'({AWREADY, WREADY, ARREADY}), 0);
    check_eq("mid_rst_ctrl_out", ctrl_out, 0);
    rst_n = 1;
    m_clear();
    @(posedge clk); @(negedge clk);
    check_eq("post_rst_bvalid", 32'(BVALID), 0);
    check_eq("post_rst_readies", 32'({AWREADY, WREADY, ARREADY}), 32'b111);
    axi_read(20'h08, 0, d, r, c);
    check_eq("post_rst_rd08", d, 0);
    rd_check("post_rst_cnt", 20'h04, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
